// File: rtl/des_iterative_controller_if.sv
// Block handshake bundle for the iterative DES controller.
// Input side carries the block in, output side carries the result out.
interface des_iterative_controller_if;
   logic        i_valid;
   logic        i_ready;
   logic [63:0] i_data;
   logic        i_decrypt;
   logic        o_valid;
   logic        o_ready;
   logic [63:0] o_data;

   modport slave (
      input  i_valid, i_data, i_decrypt, o_ready,
      output i_ready, o_valid, o_data
   );

   modport master (
      output i_valid, i_data, i_decrypt, o_ready,
      input  i_ready, o_valid, o_data
   );
endinterface

// File: rtl/des_iterative_controller.sv
// Iterative DES controller: loops one shared round function through all
// rounds of a block, applying IP on entry and swap+FP on exit.
module des_iterative_controller #(
   parameter int NUM_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   des_iterative_controller_if.slave blk,
   input  logic        hold,
   output logic        rf_enable,
   output logic        rf_i_valid,
   output logic [31:0] rf_L,
   output logic [31:0] rf_R,
   input  logic        rf_o_valid,
   input  logic [31:0] rf_L_out,
   input  logic [31:0] rf_R_out,
   output logic [3:0]  kn_sel,
   output logic        busy,
   output logic        err
);

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,
      60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,
      64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,
      59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,
      63, 55, 47, 39, 31, 23, 15, 7
   };

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,
      39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,
      37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,
      35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,
      33, 1, 41,  9, 49, 17, 57, 25
   };

   // Table entries use DES numbering: bit 1 is the MSB (index 63).
   function automatic logic [63:0] ip_f(input logic [63:0] x);
      logic [63:0] r;
      logic [5:0]  s;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         s = 6'(64 - IP_T[i]);
         r[6'(63 - i)] = x[s];
      end
      return r;
   endfunction

   function automatic logic [63:0] fp_f(input logic [63:0] x);
      logic [63:0] r;
      logic [5:0]  s;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         s = 6'(64 - FP_T[i]);
         r[6'(63 - i)] = x[s];
      end
      return r;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FINAL,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] l_q, l_d;
   logic [31:0] r_q, r_d;
   logic        dec_q, dec_d;
   logic [63:0] odata_q, odata_d;
   logic        err_q, err_d;
   logic [63:0] ip_data;
   logic [63:0] fp_data;

   // State and datapath registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         l_q     <= '0;
         r_q     <= '0;
         dec_q   <= 1'b0;
         odata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         l_q     <= l_d;
         r_q     <= r_d;
         dec_q   <= dec_d;
         odata_q <= odata_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; hold freezes everything except the two handshakes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      l_d     = l_q;
      r_d     = r_q;
      dec_d   = dec_q;
      odata_d = odata_q;
      err_d   = err_q;
      ip_data = ip_f(blk.i_data);
      fp_data = fp_f({r_q, l_q});

      if (!hold && rf_o_valid && state_q != S_WAIT)
         err_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (blk.i_valid) begin
               l_d     = ip_data[63:32];
               r_d     = ip_data[31:0];
               dec_d   = blk.i_decrypt;
               cnt_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!hold)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!hold && rf_o_valid) begin
               l_d = rf_L_out;
               r_d = rf_R_out;
               if (cnt_q == LAST) begin
                  state_d = S_FINAL;
               end else begin
                  cnt_d   = cnt_q + 4'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_FINAL: begin
            if (!hold) begin
               odata_d = fp_data;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (blk.o_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign blk.i_ready = (state_q == S_IDLE);
   assign blk.o_valid = (state_q == S_DONE);
   assign blk.o_data  = odata_q;
   assign rf_enable   = !hold;
   assign rf_i_valid  = (state_q == S_ISSUE) && !hold;
   assign rf_L        = l_q;
   assign rf_R        = r_q;
   assign kn_sel      = dec_q ? (LAST - cnt_q) : cnt_q;
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign err         = err_q;

endmodule

// File: tb/tb_des_iterative_controller.sv
// Bench for the iterative DES controller with a modelled round function
// and key store for key 133457799BBCDFF1.
module tb_des_iterative_controller;

   localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
   localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
   localparam logic [63:0] CT  = 64'h85E813540F0AB405;

   localparam int IPT [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FPT [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
      34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int ET [48] = '{
      32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
      12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
      24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int PTB [32] = '{
      16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
      2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int PC1 [56] = '{
      57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
      10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
      63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
      14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2 [48] = '{
      14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
      16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
      44,49,39,56,34,53, 46,42,50,36,29,32};
   localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   localparam int SB [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   function automatic logic [63:0] perm64(input logic [63:0] x, input logic fp);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++)
         r = (r << 1) | ((x >> (64 - (fp ? FPT[i] : IPT[i]))) & 64'd1);
      return r;
   endfunction

   function automatic logic [31:0] f_fn(input logic [31:0] rr, input logic [47:0] k);
      logic [63:0] e, x, s, p;
      int six, row, col;
      e = '0;
      for (int j = 0; j < 48; j++)
         e = (e << 1) | (({32'd0, rr} >> (32 - ET[j])) & 64'd1);
      x = e ^ {16'd0, k};
      s = '0;
      for (int b = 0; b < 8; b++) begin
         six = int'((x >> (42 - 6 * b)) & 64'd63);
         row = ((six >> 4) & 2) | (six & 1);
         col = (six >> 1) & 15;
         s = (s << 4) | 64'(SB[b * 64 + row * 16 + col]);
      end
      p = '0;
      for (int j = 0; j < 32; j++)
         p = (p << 1) | ((s >> (32 - PTB[j])) & 64'd1);
      return p[31:0];
   endfunction

   function automatic logic [47:0] subkey(input logic [63:0] key, input int n);
      logic [63:0] cd, c, d, k;
      cd = '0;
      for (int j = 0; j < 56; j++)
         cd = (cd << 1) | ((key >> (64 - PC1[j])) & 64'd1);
      c = (cd >> 28) & 64'hFFFFFFF;
      d = cd & 64'hFFFFFFF;
      for (int r = 0; r <= n; r++) begin
         c = ((c << SH[r]) | (c >> (28 - SH[r]))) & 64'hFFFFFFF;
         d = ((d << SH[r]) | (d >> (28 - SH[r]))) & 64'hFFFFFFF;
      end
      cd = (c << 28) | d;
      k = '0;
      for (int j = 0; j < 48; j++)
         k = (k << 1) | ((cd >> (56 - PC2[j])) & 64'd1);
      return k[47:0];
   endfunction

   logic [47:0] ks [16];

   function automatic logic [63:0] des_ref(input logic [63:0] x, input logic dec);
      logic [63:0] v;
      logic [31:0] l, r, t;
      v = perm64(x, 1'b0);
      l = v[63:32];
      r = v[31:0];
      for (int i = 0; i < 16; i++) begin
         t = r;
         r = l ^ f_fn(r, ks[dec ? 15 - i : i]);
         l = t;
      end
      return perm64({r, l}, 1'b1);
   endfunction

   logic clk = 1'b0;
   logic rst, hold, inj;
   logic rf_enable, rf_i_valid, rf_o_valid, rf_v_q;
   logic [31:0] rf_L, rf_R, rf_L_out, rf_R_out;
   logic [3:0] kn_sel;
   logic busy, err;

   always #5 clk = ~clk;

   des_iterative_controller_if bif ();

   des_iterative_controller #(.NUM_ROUNDS(16)) dut (
      .clk(clk), .rst(rst), .blk(bif.slave), .hold(hold),
      .rf_enable(rf_enable), .rf_i_valid(rf_i_valid),
      .rf_L(rf_L), .rf_R(rf_R), .rf_o_valid(rf_o_valid),
      .rf_L_out(rf_L_out), .rf_R_out(rf_R_out),
      .kn_sel(kn_sel), .busy(busy), .err(err)
   );

   assign rf_o_valid = rf_v_q | inj;

   // Registered single-stage round function fed from the key store.
   always @(posedge clk) begin
      if (rst) begin
         rf_v_q <= 1'b0;
      end else if (rf_enable) begin
         rf_v_q <= rf_i_valid;
         if (rf_i_valid) begin
            rf_L_out <= rf_R;
            rf_R_out <= rf_L ^ f_fn(rf_R, ks[kn_sel]);
         end
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc, lat, kn, bad, hbad;
   logic [63:0] res, kseq, expv;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input logic [63:0] x, input logic dec);
      int w;
      w = 0;
      while (!bif.i_ready && w < 100) begin
         tick;
         w++;
      end
      bif.i_valid = 1'b1;
      bif.i_data = x;
      bif.i_decrypt = dec;
      tick;
      bif.i_valid = 1'b0;
      cyc = 1;
      kn = 0;
      kseq = '0;
   endtask

   task automatic run_to_done(input int hs, input int hl);
      logic [3:0] ksnap;
      logic [31:0] lsnap;
      hbad = 0;
      ksnap = '0;
      lsnap = '0;
      while (cyc < 300) begin
         hold = (cyc >= hs) && (cyc < hs + hl);
         #1;
         if (cyc == hs) begin
            ksnap = kn_sel;
            lsnap = rf_L;
         end
         if (hold && (rf_enable !== 1'b0 || busy !== 1'b1))
            hbad++;
         if (hold && cyc > hs && (kn_sel !== ksnap || rf_L !== lsnap))
            hbad++;
         if (bif.o_valid) break;
         if (rf_i_valid) begin
            kseq = {kseq[59:0], kn_sel};
            kn++;
         end
         tick;
         cyc++;
      end
      hold = 1'b0;
      lat = cyc;
      res = bif.o_data;
   endtask

   task automatic drain(input int bp);
      bad = 0;
      for (int k = 0; k < bp; k++) begin
         if (bif.o_valid !== 1'b1 || bif.o_data !== res || bif.i_ready !== 1'b0)
            bad++;
         tick;
      end
      if (bif.o_valid !== 1'b1 || bif.o_data !== res || bif.i_ready !== 1'b0)
         bad++;
      bif.o_ready = 1'b1;
      tick;
      bif.o_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ks[i] = subkey(KEY, i);
      rst = 1'b1;
      hold = 1'b0;
      inj = 1'b0;
      bif.i_valid = 1'b0;
      bif.i_data = '0;
      bif.i_decrypt = 1'b0;
      bif.o_ready = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      tick;
      chk("rst_i_ready", 64'(bif.i_ready), 64'd1);
      chk("rst_o_valid", 64'(bif.o_valid), 64'd0);
      chk("rst_o_data", bif.o_data, 64'd0);
      chk("rst_busy_err", {62'd0, busy, err}, 64'd0);
      chk("rst_rf", {rf_enable, rf_i_valid, 30'd0, rf_L}, {1'b1, 63'd0});

      start_block(PT, 1'b0);
      run_to_done(999, 0);
      chk("enc_data", res, CT);
      chk("enc_lat", 64'(lat), 64'd34);
      chk("enc_kn_seq", kseq, 64'h0123456789ABCDEF);
      chk("enc_kn_cnt", 64'(kn), 64'd16);
      drain(0);
      chk("enc_idle", {62'd0, bif.i_ready, bif.o_valid}, 64'd2);

      start_block(CT, 1'b1);
      run_to_done(999, 0);
      chk("dec_data", res, PT);
      chk("dec_lat", 64'(lat), 64'd34);
      chk("dec_kn_seq", kseq, 64'hFEDCBA9876543210);
      drain(20);
      chk("bp_stable", 64'(bad), 64'd0);
      chk("bp_release", {62'd0, bif.i_ready, bif.o_valid}, 64'd2);

      start_block(PT, 1'b0);
      run_to_done(16, 5);
      chk("hold_data", res, CT);
      chk("hold_lat", 64'(lat), 64'd39);
      chk("hold_frozen", 64'(hbad), 64'd0);
      drain(0);

      start_block(PT, 1'b0);
      repeat (9) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_state", {60'd0, bif.i_ready, bif.o_valid, busy, err}, 64'd8);
      chk("abort_kn", 64'(kn_sel), 64'd0);
      bad = 0;
      repeat (5) begin
         tick;
         if (bif.o_valid !== 1'b0) bad++;
      end
      chk("abort_no_out", 64'(bad), 64'd0);
      start_block(PT, 1'b0);
      run_to_done(999, 0);
      chk("abort_redo", res, CT);
      chk("abort_redo_kn", kseq, 64'h0123456789ABCDEF);
      drain(0);

      inj = 1'b1;
      tick;
      inj = 1'b0;
      chk("err_set", 64'(err), 64'd1);
      start_block(PT, 1'b0);
      run_to_done(999, 0);
      chk("err_blk", res, CT);
      chk("err_sticky", 64'(err), 64'd1);
      drain(0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("err_clear", 64'(err), 64'd0);

      for (int n = 0; n < 8; n++) begin
         logic [63:0] x;
         logic d;
         int hs, hl, bp;
         x = {$urandom, $urandom};
         d = 1'($urandom_range(0, 1));
         hs = $urandom_range(2, 20);
         hl = $urandom_range(0, 4);
         bp = $urandom_range(0, 3);
         expv = des_ref(x, d);
         start_block(x, d);
         run_to_done(hs, hl);
         chk("rnd_data", res, expv);
         chk("rnd_lat", 64'(lat), 64'(34 + hl));
         chk("rnd_kn_cnt", 64'(kn), 64'd16);
         if (hl > 0) chk("rnd_hold", 64'(hbad), 64'd0);
         drain(bp);
         chk("rnd_bp", 64'(bad), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
